alu_rs_scheduler: RTL

//  Reservation station and issue scheduler for the single ALU. Holds dispatched ALU ops until

---
 rtl/alu_rs_scheduler.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs_scheduler.sv
// Reservation station for the single ALU: holds dispatched ops until both operands resolve,
// snoops the ALU and LSB result buses, and issues the lowest-index ready op once per cycle.
module alu_rs_scheduler #(
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = 3,
  parameter int OP_W     = 6,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              in_ena,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_vj,
  input  logic [DATA_W-1:0] in_vk,
  input  logic              in_qj_v,
  input  logic              in_qk_v,
  input  logic [ROB_W-1:0]  in_qj,
  input  logic [ROB_W-1:0]  in_qk,
  input  logic [ROB_W-1:0]  in_rob_tag,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  output logic              full,

  input  logic              cdb_alu_ena,
  input  logic [ROB_W-1:0]  cdb_alu_tag,
  input  logic [DATA_W-1:0] cdb_alu_data,
  input  logic              cdb_lsb_ena,
  input  logic [ROB_W-1:0]  cdb_lsb_tag,
  input  logic [DATA_W-1:0] cdb_lsb_data,

  output logic              alu_ena,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [ROB_W-1:0]  alu_rob_tag,
  output logic [DATA_W-1:0] alu_pc,
  output logic [DATA_W-1:0] alu_imm
);

  // Control bits carry the reset; the payload arrays are plain data flops.
  logic [RS_SIZE-1:0] valid;
  logic [RS_SIZE-1:0] qj_v;
  logic [RS_SIZE-1:0] qk_v;

  logic [OP_W-1:0]   op_q   [RS_SIZE];
  logic [DATA_W-1:0] vj_q   [RS_SIZE];
  logic [DATA_W-1:0] vk_q   [RS_SIZE];
  logic [ROB_W-1:0]  qj_q   [RS_SIZE];
  logic [ROB_W-1:0]  qk_q   [RS_SIZE];
  logic [ROB_W-1:0]  tag_q  [RS_SIZE];
  logic [DATA_W-1:0] pc_q   [RS_SIZE];
  logic [DATA_W-1:0] imm_q  [RS_SIZE];

  logic [RS_SIZE-1:0]  ready;
  logic                free_found;
  logic [RS_IDX_W-1:0] free_idx;
  logic                issue_found;
  logic [RS_IDX_W-1:0] issue_idx;
  logic                dispatch;

  logic [DATA_W-1:0] disp_vj;
  logic [DATA_W-1:0] disp_vk;
  logic              disp_qj_v;
  logic              disp_qk_v;

  logic [RS_SIZE-1:0] wake_j_alu;
  logic [RS_SIZE-1:0] wake_j_lsb;
  logic [RS_SIZE-1:0] wake_k_alu;
  logic [RS_SIZE-1:0] wake_k_lsb;

  assign ready    = valid & ~qj_v & ~qk_v;
  assign full     = &valid;
  assign dispatch = in_ena & ~full & ~flush;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_W'(i);
      end
    end
  end

  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = RS_IDX_W'(i);
      end
    end
  end

  // Operands produced on a CDB in the dispatch cycle are captured directly.
  always_comb begin
    disp_vj   = in_vj;
    disp_qj_v = in_qj_v;
    if (in_qj_v) begin
      if (cdb_alu_ena && cdb_alu_tag == in_qj) begin
        disp_vj   = cdb_alu_data;
        disp_qj_v = 1'b0;
      end else if (cdb_lsb_ena && cdb_lsb_tag == in_qj) begin
        disp_vj   = cdb_lsb_data;
        disp_qj_v = 1'b0;
      end
    end
  end

  always_comb begin
    disp_vk   = in_vk;
    disp_qk_v = in_qk_v;
    if (in_qk_v) begin
      if (cdb_alu_ena && cdb_alu_tag == in_qk) begin
        disp_vk   = cdb_alu_data;
        disp_qk_v = 1'b0;
      end else if (cdb_lsb_ena && cdb_lsb_tag == in_qk) begin
        disp_vk   = cdb_lsb_data;
        disp_qk_v = 1'b0;
      end
    end
  end

  // ALU bus has priority over LSB when both carry the same tag.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wake_j_alu[i] = valid[i] & qj_v[i] & cdb_alu_ena & (cdb_alu_tag == qj_q[i]);
      wake_j_lsb[i] = valid[i] & qj_v[i] & cdb_lsb_ena & (cdb_lsb_tag == qj_q[i]) & ~wake_j_alu[i];
      wake_k_alu[i] = valid[i] & qk_v[i] & cdb_alu_ena & (cdb_alu_tag == qk_q[i]);
      wake_k_lsb[i] = valid[i] & qk_v[i] & cdb_lsb_ena & (cdb_lsb_tag == qk_q[i]) & ~wake_k_alu[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= '0;
      qj_v        <= '0;
      qk_v        <= '0;
      alu_ena     <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_rob_tag <= '0;
      alu_pc      <= '0;
      alu_imm     <= '0;
    end else if (flush) begin
      valid   <= '0;
      alu_ena <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (wake_j_alu[i] || wake_j_lsb[i]) qj_v[i] <= 1'b0;
        if (wake_k_alu[i] || wake_k_lsb[i]) qk_v[i] <= 1'b0;
      end

      if (issue_found) begin
        valid[issue_idx] <= 1'b0;
        alu_ena          <= 1'b1;
        alu_op           <= op_q[issue_idx];
        alu_a            <= vj_q[issue_idx];
        alu_b            <= vk_q[issue_idx];
        alu_rob_tag      <= tag_q[issue_idx];
        alu_pc           <= pc_q[issue_idx];
        alu_imm          <= imm_q[issue_idx];
      end else begin
        alu_ena <= 1'b0;
      end

      // The free slot is never the issuing slot: the free search sees the pre-issue valid bits.
      if (dispatch && free_found) begin
        valid[free_idx] <= 1'b1;
        qj_v[free_idx]  <= disp_qj_v;
        qk_v[free_idx]  <= disp_qk_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (wake_j_alu[i])      vj_q[i] <= cdb_alu_data;
      else if (wake_j_lsb[i]) vj_q[i] <= cdb_lsb_data;
      if (wake_k_alu[i])      vk_q[i] <= cdb_alu_data;
      else if (wake_k_lsb[i]) vk_q[i] <= cdb_lsb_data;
    end

    if (dispatch && free_found) begin
      op_q[free_idx]  <= in_op;
      vj_q[free_idx]  <= disp_vj;
      vk_q[free_idx]  <= disp_vk;
      qj_q[free_idx]  <= in_qj;
      qk_q[free_idx]  <= in_qk;
      tag_q[free_idx] <= in_rob_tag;
      pc_q[free_idx]  <= in_pc;
      imm_q[free_idx] <= in_imm;
    end
  end

endmodule
